// File: rtl/rescap_seq_pkg.sv
// Shared types and default settings for the RC charge sequencer.
`timescale 1ns/1ps

package rescap_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DISCHARGE = 2'd1,
        CHARGE    = 2'd2,
        DONE      = 2'd3
    } seq_state_e;

    localparam int unsigned DEF_CNT_W         = 16;
    localparam int unsigned DEF_SETTLE_CYCLES = 500;
    localparam int unsigned DEF_MAX_CYCLES    = 4000;

    localparam real DEF_VDD_HIGH    = 1.0;
    localparam real DEF_THRESH_FRAC = 0.632;
    localparam real DEF_DISCH_LIMIT = 0.01;

    // True when val is representable in an unsigned counter of w bits.
    function automatic bit fits_width(input int unsigned val, input int unsigned w);
        return (w >= 32) || (64'(val) < (64'(1) << w));
    endfunction

endpackage

// File: rtl/rescap_cycle_counter.sv
// Phase cycle counter: load starts a phase at 1, inc advances it, at_term_c flags count==term.
// The count holds at term so it can never wrap.
`timescale 1ns/1ps

module rescap_cycle_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] count,
    output logic             at_term_c
);

    // Terminal compare for the phase currently being timed.
    assign at_term_c = (count == term);

    // Load has priority; increments stop at the terminal value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(1);
        end else if (inc && !at_term_c) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rescap_charge_sequencer.sv
// RC time-constant sequencer: discharge the network, step the supply, count cycles to threshold.
// Optional macro RESCAP_DISCHARGE_CHECK_EN: DISCHARGE also waits for node_v < DISCH_LIMIT,
// bounded by MAX_CYCLES (timeout with tau_count=0, CHARGE skipped).
`timescale 1ns/1ps

module rescap_charge_sequencer
    import rescap_seq_pkg::*;
#(
    parameter real         VDD_HIGH      = DEF_VDD_HIGH,
    parameter real         THRESH_FRAC   = DEF_THRESH_FRAC,
    parameter real         DISCH_LIMIT   = DEF_DISCH_LIMIT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_CYCLES    = DEF_MAX_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  real              node_v,
    output real              vdd_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] tau_count,
    output logic             timeout
);

    localparam real              THRESH_V = VDD_HIGH * THRESH_FRAC;
    localparam logic [CNT_W-1:0] SETTLE_T = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] MAX_T    = CNT_W'(MAX_CYCLES);

    // Elaboration-time sanity checks on the configuration.
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
        $error("rescap_charge_sequencer: CNT_W must be 1..32");
    end
    if (SETTLE_CYCLES < 1 || !fits_width(SETTLE_CYCLES, CNT_W)) begin : g_bad_settle
        $error("rescap_charge_sequencer: SETTLE_CYCLES must be >=1 and < 2**CNT_W");
    end
    if (MAX_CYCLES < 1 || !fits_width(MAX_CYCLES, CNT_W)) begin : g_bad_max
        $error("rescap_charge_sequencer: MAX_CYCLES must be >=1 and < 2**CNT_W");
    end
    if (DISCH_LIMIT < 0.0) begin : g_bad_disch
        $error("rescap_charge_sequencer: DISCH_LIMIT must be non-negative");
    end

    seq_state_e       state;
    seq_state_e       state_nxt;
    logic             cnt_load;
    logic             cnt_inc;
    logic [CNT_W-1:0] cnt_term;
    logic [CNT_W-1:0] count;
    logic             at_term_c;
    logic             cross_c;
    logic [CNT_W-1:0] tau_nxt;
    logic             timeout_nxt;

    rescap_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .term      (cnt_term),
        .count     (count),
        .at_term_c (at_term_c)
    );

    // Real-valued threshold compare, consumed only at the clock edge.
    assign cross_c = (node_v >= THRESH_V);

    // Next-state, counter control and result update.
    always_comb begin
        state_nxt   = state;
        cnt_load    = 1'b0;
        cnt_inc     = 1'b0;
        cnt_term    = MAX_T;
        tau_nxt     = tau_count;
        timeout_nxt = timeout;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = DISCHARGE;
                    cnt_load    = 1'b1;
                    tau_nxt     = '0;
                    timeout_nxt = 1'b0;
                end
            end
            DISCHARGE: begin
                cnt_inc = 1'b1;
`ifdef RESCAP_DISCHARGE_CHECK_EN
                cnt_term = MAX_T;
                if (count >= SETTLE_T && node_v < DISCH_LIMIT) begin
                    state_nxt = CHARGE;
                    cnt_load  = 1'b1;
                end else if (at_term_c) begin
                    state_nxt   = DONE;
                    tau_nxt     = '0;
                    timeout_nxt = 1'b1;
                end
`else
                cnt_term = SETTLE_T;
                if (at_term_c) begin
                    state_nxt = CHARGE;
                    cnt_load  = 1'b1;
                end
`endif
            end
            CHARGE: begin
                cnt_inc  = 1'b1;
                cnt_term = MAX_T;
                if (cross_c) begin
                    state_nxt = DONE;
                    tau_nxt   = count;
                end else if (at_term_c) begin
                    state_nxt   = DONE;
                    tau_nxt     = MAX_T;
                    timeout_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            vdd_out   <= 0.0;
            busy      <= 1'b0;
            done      <= 1'b0;
            tau_count <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nxt;
            vdd_out   <= (state_nxt == CHARGE) ? VDD_HIGH : 0.0;
            busy      <= (state_nxt == DISCHARGE) || (state_nxt == CHARGE);
            done      <= (state_nxt == DONE);
            tau_count <= tau_nxt;
            timeout   <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_rescap_charge_sequencer.sv
// Bench for rescap_charge_sequencer: a behavioural RC network (1 ns clock) plus a
// phase-level predictor of discharge length, charge length, tau and timeout.
`timescale 1ns/1ps

module tb_rescap_charge_sequencer;

    localparam int unsigned CNT_W  = 16;
`ifdef RESCAP_DISCHARGE_CHECK_EN
    localparam int unsigned SETTLE = 10;
`else
    localparam int unsigned SETTLE = 500;
`endif
    localparam int unsigned MAXC   = 4000;
    localparam real         VDD    = 1.0;
    localparam real         FRAC   = 0.632;
    localparam real         LIM    = 0.01;
    localparam real         THRESH = VDD * FRAC;

    logic             clk;
    logic             reset;
    logic             start;
    real              node_v;
    real              vdd_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] tau_count;
    logic             timeout;

    int  n_total;
    int  n_bad;
    real rc_a;
    bit  rc_zero;

    rescap_charge_sequencer #(
        .VDD_HIGH      (VDD),
        .THRESH_FRAC   (FRAC),
        .DISCH_LIMIT   (LIM),
        .SETTLE_CYCLES (SETTLE),
        .MAX_CYCLES    (MAXC),
        .CNT_W         (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .node_v    (node_v),
        .vdd_out   (vdd_out),
        .busy      (busy),
        .done      (done),
        .tau_count (tau_count),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #0.5 clk = ~clk;

    // One clock period of exact first-order RC response toward vdd.
    function automatic real rc_step(input real v, input real vdd);
        return vdd + (v - vdd) * rc_a;
    endfunction

    // RC network: node moves at mid-cycle so it is stable at every rising edge.
    always @(negedge clk) begin
        if (rc_zero) node_v = 0.0;
        else         node_v = rc_step(node_v, vdd_out);
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #0.1;
    endtask

    // Predict a measurement from the node voltage seen at the accepting edge.
    task automatic predict(input real v0, output int d, output int c, output int tau, output bit to);
        real v;
        v = v0; d = 0; c = 0; tau = 0; to = 1'b0;
        for (int k = 1; k <= int'(MAXC); k++) begin
            v = rc_step(v, 0.0);
            d = k;
`ifdef RESCAP_DISCHARGE_CHECK_EN
            if (k >= int'(SETTLE) && v < LIM) break;
            if (k == int'(MAXC)) begin
                to = 1'b1;
                return;
            end
`else
            if (k == int'(SETTLE)) break;
`endif
        end
        for (int k = 1; k <= int'(MAXC); k++) begin
            v = rc_step(v, VDD);
            c = k;
            if (v >= THRESH) begin
                tau = k;
                return;
            end
            if (k == int'(MAXC)) begin
                tau = int'(MAXC);
                to  = 1'b1;
                return;
            end
        end
    endtask

    // Full measurement from an IDLE cycle; optional stray start in charge cycle pulse_at.
    task automatic measure(input int pulse_at, output int tau_got);
        int  d_exp, c_exp, tau_exp, n_d, n_c, n_dn;
        bit  to_exp;
        real v0;
        start = 1'b1;
        tick();
        start = 1'b0;
        v0 = node_v;
        predict(v0, d_exp, c_exp, tau_exp, to_exp);
        chk("busy_rise", busy, 1);
        chk("tau_clear", tau_count, 0);
        chk("to_clear", timeout, 0);
        n_d = 0; n_c = 0; n_dn = 0;
        while (busy && vdd_out == 0.0 && n_d <= int'(MAXC)) begin
            n_d++;
            n_dn += int'(done);
            tick();
        end
        while (busy && vdd_out == VDD && n_c <= int'(MAXC)) begin
            n_c++;
            n_dn += int'(done);
            start = (n_c == pulse_at);
            tick();
        end
        start = 1'b0;
        chk("dis_cycles", n_d, d_exp);
        chk("chg_cycles", n_c, c_exp);
        chk("early_done", n_dn, 0);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_vdd0", vdd_out == 0.0, 1);
        chk("tau", tau_count, tau_exp);
        chk("timeout", timeout, to_exp);
        tau_got = int'(tau_count);
        tick();
        chk("done_drop", done, 0);
        chk("idle_busy", busy, 0);
        chk("tau_hold", tau_count, tau_exp);
        chk("to_hold", timeout, to_exp);
    endtask

    initial begin
        int t1, t2, t;
        int n, dn;
        n_total = 0;
        n_bad   = 0;
        reset   = 1'b1;
        start   = 1'b0;
        rc_zero = 1'b1;
        rc_a    = $exp(-1.0 / 100.0);
        #0.2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tau", tau_count, 0);
        chk("rst_to", timeout, 0);
        chk("rst_vdd0", vdd_out == 0.0, 1);
        tick();
        tick();
        reset = 1'b0;
        tick();
        rc_zero = 1'b0;
        tick();
        chk("idle_busy0", busy, 0);

        // Nominal tau = 100 cycles from a fully discharged node, then back-to-back.
        measure(0, t1);
        chk("tau_near_100", (t1 >= 99 && t1 <= 101), 1);
        measure(0, t2);
        chk("b2b_repeat", (t2 - t1 <= 1 && t1 - t2 <= 1), 1);
        measure(37, t);

        // Randomized RC constants, idle gaps and stray starts during charge.
        for (int i = 0; i < 8; i++) begin
            n = int'($urandom_range(0, 4));
            for (int j = 0; j < n; j++) tick();
            rc_a = $exp(-1.0 / real'($urandom_range(20, 300)));
            measure(int'($urandom_range(0, 60)), t);
        end

        // Slow network: no crossing within MAX_CYCLES.
        rc_zero = 1'b1;
        tick();
        tick();
        rc_zero = 1'b0;
        rc_a = $exp(-1.0 / 4100.0);
        measure(0, t);
        chk("timeout_tau", t, MAXC);

        // Crossing lands on the MAX_CYCLES edge: crossing wins.
        rc_zero = 1'b1;
        tick();
        tick();
        rc_zero = 1'b0;
        rc_a = $exp(-1.0 / 4001.0);
        measure(0, t);
        chk("tie_tau", t, MAXC);
        chk("tie_no_to", timeout, 0);

        // Asynchronous reset in the middle of CHARGE.
        rc_a  = $exp(-1.0 / 100.0);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (vdd_out != VDD && n < 5000) begin
            n++;
            tick();
        end
        chk("reach_charge", vdd_out == VDD, 1);
        for (int j = 0; j < 20; j++) tick();
        #0.2;
        reset = 1'b1;
        #0.05;
        chk("arst_busy", busy, 0);
        chk("arst_vdd0", vdd_out == 0.0, 1);
        chk("arst_tau", tau_count, 0);
        chk("arst_to", timeout, 0);
        dn = int'(done);
        for (int j = 0; j < 3; j++) begin
            tick();
            dn += int'(done);
        end
        chk("arst_no_done", dn, 0);
        reset = 1'b0;
        tick();
        chk("post_rst_busy", busy, 0);
        measure(0, t);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
